// File: rtl/spi_apb_master_if.sv
// Bus bundle for spi_apb_master: local request/response channel plus APB initiator pins.
// The design attaches through 'master'; the sequencer/APB-slave side attaches through 'slave'.
interface spi_apb_master_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_valid;
  logic                      req_ready;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;
  logic                      req_write;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/spi_apb_master.sv
// APB initiator for the SPI master register block: one outstanding request turned
// into an APB SETUP/ACCESS transfer, with optional ACCESS-phase timeout.
module spi_apb_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  spi_apb_master_if.master     bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      to_expire;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_to
      assign to_expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_to
      assign to_expire = 1'b0;
    end
  endgenerate

  // The APB bus phases trail the FSM by one cycle: the state after SETUP first
  // shows PSEL alone, then raises PENABLE, and only then looks at PREADY.
  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          pwrite_d = bus.req_write;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (!penable_q) begin
          penable_d = 1'b1;
        end else if (bus.PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? 32'h0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (to_expire) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
endmodule
